// File: rtl/dma_line_ctrl.sv
// Line-granular DMA controller: turns CPU word read/write commands into 512-bit host line transactions.
// Build macro DMA_LINE_CTRL_TIMEOUT_EN bounds host waits to TIMEOUT_CYCLES and raises a sticky err.
module dma_line_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   op,
  input  logic [63:0]  io_address,
  input  logic [31:0]  cpu_data_in,
  output logic [31:0]  cpu_data_out,
  output logic         rd_valid,
  output logic         tx_done,
  output logic         busy,
  output logic         host_rd_req,
  output logic [57:0]  host_rd_addr,
  input  logic         host_rd_ready,
  input  logic         host_rd_valid,
  input  logic [511:0] host_rd_data,
  output logic         host_wr_req,
  output logic [57:0]  host_wr_addr,
  output logic [511:0] host_wr_data,
  input  logic         host_wr_ready,
  input  logic         host_wr_ack,
  output logic         err
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, RD_STREAM, WR_FILL, WR_REQ, WR_WAIT, DONE
  } state_t;

  state_t       state, state_nxt;
  logic [3:0]   cnt;
  logic [511:0] line;
  logic [57:0]  line_addr;
  logic         rd_cap;
  logic         timeout;
  logic         to_abort;
  logic         unused_bits;

  assign unused_bits = (^io_address[5:0]) ^ (TIMEOUT_CYCLES == 0) ^ to_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    rd_cap       = 1'b0;
    to_abort     = 1'b0;
    busy         = (state != IDLE);
    rd_valid     = 1'b0;
    cpu_data_out = '0;
    tx_done      = 1'b0;
    host_rd_req  = 1'b0;
    host_rd_addr = '0;
    host_wr_req  = 1'b0;
    host_wr_addr = '0;
    host_wr_data = '0;
    case (state)
      IDLE: begin
        if (op == 2'b01)      state_nxt = RD_REQ;
        else if (op == 2'b11) state_nxt = WR_FILL;
      end
      RD_REQ: begin
        host_rd_req  = 1'b1;
        host_rd_addr = line_addr;
        if (host_rd_ready) begin
          rd_cap    = host_rd_valid;
          state_nxt = host_rd_valid ? RD_STREAM : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (host_rd_valid) begin
          rd_cap    = 1'b1;
          state_nxt = RD_STREAM;
        end
      end
      RD_STREAM: begin
        rd_valid     = 1'b1;
        cpu_data_out = line[{cnt, 5'b0} +: 32];
        if (cnt == 4'd15) state_nxt = DONE;
      end
      WR_FILL: begin
        if (cnt == 4'd15) state_nxt = WR_REQ;
      end
      WR_REQ: begin
        host_wr_req  = 1'b1;
        host_wr_addr = line_addr;
        host_wr_data = line;
        if (host_wr_ready) state_nxt = host_wr_ack ? DONE : WR_WAIT;
      end
      WR_WAIT: begin
        if (host_wr_ack) state_nxt = DONE;
      end
      DONE: begin
        tx_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A timeout only wins when the host made no progress this cycle
    if (timeout && state_nxt == state) begin
      state_nxt = DONE;
      to_abort  = 1'b1;
    end
  end

  // op[0] is set exactly for the two real commands (01 read, 11 write)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      line      <= '0;
      line_addr <= '0;
    end else begin
      if (state == IDLE && op[0]) line_addr <= io_address[63:6];
      if (rd_cap)                 line <= host_rd_data;
      else if (state == WR_FILL)  line[{cnt, 5'b0} +: 32] <= cpu_data_in;
      cnt <= (state == RD_STREAM || state == WR_FILL) ? cnt + 4'd1 : 4'd0;
    end
  end

`ifdef DMA_LINE_CTRL_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        err_q;

  assign timeout = (state inside {RD_REQ, RD_WAIT, WR_REQ, WR_WAIT}) &&
                   (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state inside {RD_REQ, RD_WAIT, WR_REQ, WR_WAIT}) wait_cnt <= wait_cnt + 16'd1;
      else                                                 wait_cnt <= '0;
      if (to_abort) err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_dma_line_ctrl.sv
// Bench for dma_line_ctrl: per-cycle expected timeline built from transaction timing rules.
`timescale 1ns/1ps
module tb_dma_line_ctrl;
  localparam int N = 700;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [1:0]   op;
  logic [63:0]  io_address;
  logic [31:0]  cpu_data_in;
  logic [31:0]  cpu_data_out;
  logic         rd_valid, tx_done, busy;
  logic         host_rd_req, host_rd_ready, host_rd_valid;
  logic [57:0]  host_rd_addr;
  logic [511:0] host_rd_data;
  logic         host_wr_req, host_wr_ready, host_wr_ack;
  logic [57:0]  host_wr_addr;
  logic [511:0] host_wr_data;
  logic         err;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  bit         exp_busy[N], exp_rd_req[N], exp_wr_req[N], exp_rd_valid[N], exp_tx_done[N], exp_err[N];
  bit [57:0]  exp_rd_addr[N], exp_wr_addr[N];
  bit [31:0]  exp_data[N];
  bit [511:0] exp_wr_data[N];

  dma_line_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .io_address(io_address),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out), .rd_valid(rd_valid),
    .tx_done(tx_done), .busy(busy), .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr),
    .host_rd_ready(host_rd_ready), .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data),
    .host_wr_req(host_wr_req), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_wr_ready(host_wr_ready), .host_wr_ack(host_wr_ack), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  function automatic logic [511:0] make_line(input logic [31:0] base);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_from(input int n);
    for (int i = n; i < N; i++) begin
      exp_busy[i] = 0; exp_rd_req[i] = 0; exp_wr_req[i] = 0; exp_rd_valid[i] = 0;
      exp_tx_done[i] = 0; exp_err[i] = 0; exp_rd_addr[i] = '0; exp_wr_addr[i] = '0;
      exp_data[i] = '0; exp_wr_data[i] = '0;
    end
  endtask

  // Read sampled at t, ready seen at r, data seen at h.
  task automatic exp_read(input int t, input int r, input int h, input logic [57:0] la,
                          input logic [31:0] base);
    for (int c = t + 1; c <= h + 17; c++) exp_busy[c] = 1;
    for (int c = t + 1; c <= r; c++) begin exp_rd_req[c] = 1; exp_rd_addr[c] = la; end
    for (int i = 0; i < 16; i++) begin
      exp_rd_valid[h + 1 + i] = 1;
      exp_data[h + 1 + i]     = base + 32'(i);
    end
    exp_tx_done[h + 17] = 1;
  endtask

  // Write sampled at t, ready seen at r, ack seen at k.
  task automatic exp_write(input int t, input int r, input int k, input logic [57:0] la,
                           input logic [31:0] base);
    for (int c = t + 1; c <= k + 1; c++) exp_busy[c] = 1;
    for (int c = t + 17; c <= r; c++) begin
      exp_wr_req[c] = 1; exp_wr_addr[c] = la; exp_wr_data[c] = make_line(base);
    end
    exp_tx_done[k + 1] = 1;
  endtask

  task automatic run_read(input logic [63:0] a, input logic [31:0] base, input int rdy_dly,
                          input int vld_gap, input logic [1:0] next_op, input int abort_word,
                          output logic [57:0] seen_addr, output logic [31:0] first_w,
                          output logic [31:0] last_w);
    int t, r, h;
    t = cyc; r = t + 1 + rdy_dly; h = r + vld_gap;
    seen_addr = '0; first_w = '0; last_w = '0;
    op = 2'b01; io_address = a;
    exp_read(t, r, h, a[63:6], base);
    step();
    for (int c = t + 1; c <= h; c++) begin
      op            = next_op;
      host_rd_ready = (c == r);
      host_rd_valid = (c == h);
      host_rd_data  = (c == h) ? make_line(base) : make_line(32'hDEAD0000);
      if (c == t + 1) seen_addr = host_rd_addr;
      step();
    end
    host_rd_ready = 1'b0; host_rd_valid = 1'b0; host_rd_data = make_line(32'hDEAD0000);
    for (int c = h + 1; c <= h + 17; c++) begin
      if (c - h - 1 == abort_word) begin
        rst_n = 1'b0;
        clear_from(c);
        return;
      end
      if (c == h + 1)  first_w = cpu_data_out;
      if (c == h + 16) last_w  = cpu_data_out;
      step();
    end
  endtask

  task automatic run_write(input logic [63:0] a, input logic [31:0] base, input int rdy_dly,
                           input int ack_gap, input logic [1:0] next_op,
                           output logic [57:0] seen_addr, output logic [511:0] seen_line);
    int t, r, k;
    t = cyc; r = t + 17 + rdy_dly; k = r + ack_gap;
    op = 2'b11; io_address = a; cpu_data_in = 32'hFFFF0000;
    exp_write(t, r, k, a[63:6], base);
    step();
    for (int c = t + 1; c <= t + 16; c++) begin
      op = next_op;
      cpu_data_in = base + 32'(c - t - 1);
      step();
    end
    cpu_data_in = 32'hFFFF0001;
    seen_addr = host_wr_addr;
    seen_line = host_wr_data;
    for (int c = t + 17; c <= k; c++) begin
      host_wr_ready = (c == r);
      host_wr_ack   = (c == k);
      step();
    end
    host_wr_ready = 1'b0; host_wr_ack = 1'b0;
    step();
  endtask

  always @(negedge clk) begin
    if (cyc < N) begin
      check("busy", 512'(busy), 512'(exp_busy[cyc]));
      check("rd_valid", 512'(rd_valid), 512'(exp_rd_valid[cyc]));
      check("tx_done", 512'(tx_done), 512'(exp_tx_done[cyc]));
      check("host_rd_req", 512'(host_rd_req), 512'(exp_rd_req[cyc]));
      check("host_wr_req", 512'(host_wr_req), 512'(exp_wr_req[cyc]));
      check("err", 512'(err), 512'(exp_err[cyc]));
      if (exp_rd_valid[cyc]) check("cpu_data_out", 512'(cpu_data_out), 512'(exp_data[cyc]));
      if (exp_rd_req[cyc]) check("host_rd_addr", 512'(host_rd_addr), 512'(exp_rd_addr[cyc]));
      if (exp_wr_req[cyc]) begin
        check("host_wr_addr", 512'(host_wr_addr), 512'(exp_wr_addr[cyc]));
        check("host_wr_data", host_wr_data, exp_wr_data[cyc]);
      end
    end
  end

  initial begin
    logic [57:0]  sa;
    logic [31:0]  fw, lw, w;
    logic [511:0] sl;
    int t;
    op = 2'b00; io_address = '0; cpu_data_in = '0;
    host_rd_ready = 1'b0; host_rd_valid = 1'b0; host_rd_data = '0;
    host_wr_ready = 1'b0; host_wr_ack = 1'b0;
    rst_n = 1'b0;
    step(); step();
    check("rst_busy", 512'(busy), 512'(1'b0));
    check("rst_data_out", 512'(cpu_data_out), 512'(32'h0));
    check("rst_wr_data", host_wr_data, 512'(0));
    rst_n = 1'b1;
    step();

    // Plain read: ready at once, data three cycles later
    run_read(64'h400, 32'hA000, 0, 3, 2'b00, -1, sa, fw, lw);
    check("rd_addr_pin", 512'(sa), 512'(58'h10));
    check("rd_first_pin", 512'(fw), 512'(32'hA000));
    check("rd_last_pin", 512'(lw), 512'(32'hA00F));

    // Plain write with delayed ready and ack
    run_write(64'h400, 32'hB000, 2, 3, 2'b00, sa, sl);
    check("wr_addr_pin", 512'(sa), 512'(58'h10));
    w = sl[191:160];
    check("wr_word5_pin", 512'(w), 512'(32'hB005));
    w = sl[511:480];
    check("wr_word15_pin", 512'(w), 512'(32'hB00F));

    // Same-cycle handshakes
    run_read(64'h1_2345_6780, 32'h5100, 0, 0, 2'b00, -1, sa, fw, lw);
    check("rd_fast_addr_pin", 512'(sa), 512'(58'h48D159E));
    check("rd_fast_first_pin", 512'(fw), 512'(32'h5100));
    run_write(64'h7_0000_0040, 32'h6200, 0, 0, 2'b00, sa, sl);
    check("wr_fast_addr_pin", 512'(sa), 512'(58'h1C000001));

    // Back-to-back: write command held through the read's tx_done
    run_read(64'h1000, 32'hC000, 1, 1, 2'b11, -1, sa, fw, lw);
    run_write(64'h2040, 32'hD000, 1, 1, 2'b00, sa, sl);
    w = sl[31:0];
    check("b2b_word0_pin", 512'(w), 512'(32'hD000));

    // Reset during stream word 7, then a stale host response
    run_read(64'h3000, 32'hE000, 0, 1, 2'b00, 7, sa, fw, lw);
    #1;
    check("abort_busy", 512'(busy), 512'(1'b0));
    check("abort_rd_valid", 512'(rd_valid), 512'(1'b0));
    check("abort_data_out", 512'(cpu_data_out), 512'(32'h0));
    step();
    step();
    rst_n = 1'b1;
    step();
    host_rd_valid = 1'b1; host_rd_ready = 1'b1; host_rd_data = make_line(32'hE000);
    step();
    host_rd_valid = 1'b0; host_rd_ready = 1'b0;
    step();
    check("stale_busy", 512'(busy), 512'(1'b0));
    step(); step();

    // Recovery after abort
    run_read(64'h3000, 32'hF000, 0, 2, 2'b00, -1, sa, fw, lw);
    check("recover_first_pin", 512'(fw), 512'(32'hF000));

`ifdef DMA_LINE_CTRL_TIMEOUT_EN
    t = cyc;
    op = 2'b01; io_address = 64'h8000;
    for (int c = t + 1; c <= t + 9; c++) exp_busy[c] = 1;
    for (int c = t + 1; c <= t + 8; c++) begin exp_rd_req[c] = 1; exp_rd_addr[c] = 58'h200; end
    exp_tx_done[t + 9] = 1;
    for (int c = t + 9; c < N; c++) exp_err[c] = 1;
    step();
    op = 2'b00;
    repeat (9) step();
    check("timeout_err_pin", 512'(err), 512'(1'b1));
    run_read(64'h400, 32'h7000, 0, 1, 2'b00, -1, sa, fw, lw);
    check("timeout_err_sticky", 512'(err), 512'(1'b1));
`else
    t = cyc;
    check("err_tied_low", 512'(err), 512'(1'b0));
`endif

    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
